// File: rtl/xor_crypt_sequencer.sv
// Serial loader and one-pass sequencer for the xor_encrypt datapath; first ciphertext bit follows iStart by NUM_CHUNKS+3 edges.
// Every register and output holds while ena is low; oDp_ena is also gated by ena so the datapath freezes together with the sequencer.
module xor_crypt_sequencer #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          iSerial_in,
    input  logic                          iLoad_msg,
    input  logic                          iLoad_key,
    input  logic                          iStart,
    input  logic [MSG_SIZE-1:0]           iCiphertext,
    output logic [MSG_SIZE-1:0]           oMessage,
    output logic [KEY_SIZE-1:0]           oKey,
    output logic [$clog2(MSG_SIZE):0]     oMessage_bit_counter,
    output logic [$clog2(KEY_SIZE):0]     oKey_bit_counter,
    output logic                          oDp_ena,
    output logic                          oDp_rst_n,
    output logic                          oSerial_out,
    output logic                          oSerial_valid,
    output logic                          oBusy,
    output logic                          oDone
);

    localparam int NUM_CHUNKS = MSG_SIZE / KEY_SIZE;
    localparam int MCW        = $clog2(MSG_SIZE) + 1;
    localparam int KCW        = $clog2(KEY_SIZE) + 1;
    localparam int CCW        = $clog2(NUM_CHUNKS) + 1;

    localparam logic [MCW-1:0] MSG_FULL   = MCW'(MSG_SIZE);
    localparam logic [KCW-1:0] KEY_FULL   = KCW'(KEY_SIZE);
    localparam logic [CCW-1:0] LAST_CHUNK = CCW'(NUM_CHUNKS - 1);
    localparam logic [MCW-1:0] LAST_BIT   = MCW'(MSG_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_CAP,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q,   state_d;
    logic [MSG_SIZE-1:0]   msg_q,     msg_d;
    logic [KEY_SIZE-1:0]   key_q,     key_d;
    logic [MCW-1:0]        mcnt_q,    mcnt_d;
    logic [KCW-1:0]        kcnt_q,    kcnt_d;
    logic [CCW-1:0]        chunk_q,   chunk_d;
    logic [MCW-1:0]        scnt_q,    scnt_d;
    logic [MSG_SIZE-1:0]   shreg_q,   shreg_d;
    logic                  dp_ena_q,  dp_ena_d;
    logic                  dp_rstn_q, dp_rstn_d;
    logic                  ser_out_q, ser_out_d;
    logic                  ser_vld_q, ser_vld_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic msg_full;
    logic key_full;

    assign msg_full = (mcnt_q == MSG_FULL);
    assign key_full = (kcnt_q == KEY_FULL);

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        key_d     = key_q;
        mcnt_d    = mcnt_q;
        kcnt_d    = kcnt_q;
        chunk_d   = chunk_q;
        scnt_d    = scnt_q;
        shreg_d   = shreg_q;
        dp_ena_d  = dp_ena_q;
        dp_rstn_d = dp_rstn_q;
        ser_out_d = ser_out_q;
        ser_vld_d = ser_vld_q;
        busy_d    = busy_q;
        done_d    = done_q;

        if (ena) begin
            ser_out_d = 1'b0;
            ser_vld_d = 1'b0;
            done_d    = 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (iStart && msg_full && key_full) begin
                        state_d = S_CLR;
                    end else if (iLoad_msg) begin
                        // A message strobe always wins the shared serial pin, even when saturated.
                        if (!msg_full) begin
                            msg_d  = {msg_q[MSG_SIZE-2:0], iSerial_in};
                            mcnt_d = mcnt_q + MCW'(1);
                        end
                    end else if (iLoad_key && !key_full) begin
                        key_d  = {key_q[KEY_SIZE-2:0], iSerial_in};
                        kcnt_d = kcnt_q + KCW'(1);
                    end
                end
                S_CLR: begin
                    chunk_d = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    chunk_d = chunk_q + CCW'(1);
                    if (chunk_q == LAST_CHUNK) begin
                        state_d = S_CAP;
                    end
                end
                S_CAP: begin
                    shreg_d = iCiphertext;
                    scnt_d  = '0;
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    ser_vld_d = 1'b1;
                    ser_out_d = shreg_q[MSG_SIZE-1];
                    shreg_d   = {shreg_q[MSG_SIZE-2:0], 1'b0};
                    scnt_d    = scnt_q + MCW'(1);
                    if (scnt_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    msg_d   = '0;
                    key_d   = '0;
                    mcnt_d  = '0;
                    kcnt_d  = '0;
                    shreg_d = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Datapath controls follow the state being entered so they line up with it.
            dp_rstn_d = (state_d != S_CLR);
            dp_ena_d  = (state_d == S_RUN);
            busy_d    = (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            msg_q     <= '0;
            key_q     <= '0;
            mcnt_q    <= '0;
            kcnt_q    <= '0;
            chunk_q   <= '0;
            scnt_q    <= '0;
            shreg_q   <= '0;
            dp_ena_q  <= 1'b0;
            dp_rstn_q <= 1'b1;
            ser_out_q <= 1'b0;
            ser_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            key_q     <= key_d;
            mcnt_q    <= mcnt_d;
            kcnt_q    <= kcnt_d;
            chunk_q   <= chunk_d;
            scnt_q    <= scnt_d;
            shreg_q   <= shreg_d;
            dp_ena_q  <= dp_ena_d;
            dp_rstn_q <= dp_rstn_d;
            ser_out_q <= ser_out_d;
            ser_vld_q <= ser_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign oMessage             = msg_q;
    assign oKey                 = key_q;
    assign oMessage_bit_counter = mcnt_q;
    assign oKey_bit_counter     = kcnt_q;
    // Gated combinationally so the datapath cannot advance during the first frozen cycle.
    assign oDp_ena              = dp_ena_q & ena;
    assign oDp_rst_n            = dp_rstn_q;
    assign oSerial_out          = ser_out_q;
    assign oSerial_valid        = ser_vld_q;
    assign oBusy                = busy_q;
    assign oDone                = done_q;

endmodule

// File: tb/tb_xor_crypt_sequencer.sv
// Bench for xor_crypt_sequencer with a behavioural xor_encrypt datapath and a serial-bit scoreboard.
module tb_xor_crypt_sequencer;

    localparam int MSG_SIZE   = 64;
    localparam int KEY_SIZE   = 8;
    localparam int NUM_CHUNKS = MSG_SIZE / KEY_SIZE;

    logic                 clk;
    logic                 rst_n;
    logic                 ena;
    logic                 iSerial_in;
    logic                 iLoad_msg;
    logic                 iLoad_key;
    logic                 iStart;
    logic [MSG_SIZE-1:0]  iCiphertext;
    logic [MSG_SIZE-1:0]  oMessage;
    logic [KEY_SIZE-1:0]  oKey;
    logic [6:0]           oMessage_bit_counter;
    logic [3:0]           oKey_bit_counter;
    logic                 oDp_ena;
    logic                 oDp_rst_n;
    logic                 oSerial_out;
    logic                 oSerial_valid;
    logic                 oBusy;
    logic                 oDone;

    xor_crypt_sequencer #(.MSG_SIZE(MSG_SIZE), .KEY_SIZE(KEY_SIZE)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ena                  (ena),
        .iSerial_in           (iSerial_in),
        .iLoad_msg            (iLoad_msg),
        .iLoad_key            (iLoad_key),
        .iStart               (iStart),
        .iCiphertext          (iCiphertext),
        .oMessage             (oMessage),
        .oKey                 (oKey),
        .oMessage_bit_counter (oMessage_bit_counter),
        .oKey_bit_counter     (oKey_bit_counter),
        .oDp_ena              (oDp_ena),
        .oDp_rst_n            (oDp_rst_n),
        .oSerial_out          (oSerial_out),
        .oSerial_valid        (oSerial_valid),
        .oBusy                (oBusy),
        .oDone                (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural xor_encrypt: one key-wide chunk per enabled cycle, cleared by its reset.
    logic dp_rst_n;
    int   dp_idx;
    assign dp_rst_n = oDp_rst_n & rst_n;

    always @(posedge clk or negedge dp_rst_n) begin
        if (!dp_rst_n) begin
            iCiphertext <= '0;
            dp_idx      <= 0;
        end else if (oDp_ena) begin
            if (dp_idx < NUM_CHUNKS)
                iCiphertext[dp_idx*KEY_SIZE +: KEY_SIZE] <= oMessage[dp_idx*KEY_SIZE +: KEY_SIZE] ^ oKey;
            dp_idx <= dp_idx + 1;
        end
    end

    int   cyc = 0;
    logic ena_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        ena_at_edge <= ena;
    end

    logic sb_q[$];
    int   bit_cnt   = 0;
    int   first_cyc = 0;
    int   last_cyc  = 0;
    int   done_cnt  = 0;
    int   done_cyc  = 0;

    always @(negedge clk) begin
        if (rst_n && ena_at_edge) begin
            if (oSerial_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    chk("ser_bit", 64'(oSerial_out), 64'(sb_q.pop_front()));
                end
                if (bit_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                bit_cnt++;
            end
            if (oDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_expected(input logic [63:0] ct);
        for (int i = MSG_SIZE - 1; i >= 0; i--) sb_q.push_back(ct[i]);
    endtask

    function automatic logic [63:0] ref_cipher(input logic [63:0] m, input logic [7:0] k);
        logic [63:0] r;
        for (int c = 0; c < NUM_CHUNKS; c++) r[c*8 +: 8] = m[c*8 +: 8] ^ k;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; iSerial_in = 1'b0;
        iLoad_msg = 1'b0; iLoad_key = 1'b0; iStart = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [63:0] v, input int n, input logic lm, input logic lk);
        for (int i = n - 1; i >= 0; i--) begin
            @(posedge clk);
            #1 iSerial_in = v[i]; iLoad_msg = lm; iLoad_key = lk;
        end
        @(posedge clk);
        #1 iSerial_in = 1'b0; iLoad_msg = 1'b0; iLoad_key = 1'b0;
    endtask

    int start_cyc = 0;
    task automatic pulse_start();
        @(posedge clk);
        #1 iStart = 1'b1;
        @(posedge clk);
        #1 iStart = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t  = 0;
        while (done_cnt == d0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1 chk("pass_done_seen", 64'(done_cnt != d0), 64'd1);
    endtask

    initial begin
        logic [63:0] a, b, msg2;
        logic [7:0]  k2;
        logic        held;

        // Reset values
        do_reset();
        chk("rst_busy", 64'(oBusy), 64'd0);
        chk("rst_dp_rst_n", 64'(oDp_rst_n), 64'd1);
        chk("rst_dp_ena", 64'(oDp_ena), 64'd0);
        chk("rst_msg", oMessage, 64'd0);
        chk("rst_key", 64'(oKey), 64'd0);
        chk("rst_mcnt", 64'(oMessage_bit_counter), 64'd0);
        chk("rst_kcnt", 64'(oKey_bit_counter), 64'd0);
        chk("rst_vld", 64'(oSerial_valid), 64'd0);
        chk("rst_done", 64'(oDone), 64'd0);

        // Simultaneous strobes shift only the message
        a = 64'h0000_0000_0000_00B7;
        shift_bits(a, 8, 1'b1, 1'b1);
        chk("both_mcnt", 64'(oMessage_bit_counter), 64'd8);
        chk("both_kcnt", 64'(oKey_bit_counter), 64'd0);
        chk("both_key", 64'(oKey), 64'd0);
        chk("both_msg", oMessage, a);

        // Saturation: extra strobes beyond the register width are ignored
        do_reset();
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        shift_bits(a, 64, 1'b1, 1'b0);
        shift_bits(b, 6, 1'b1, 1'b0);
        chk("sat_mcnt", 64'(oMessage_bit_counter), 64'd64);
        chk("sat_msg", oMessage, a);
        k2 = 8'($urandom);
        shift_bits(64'(k2), 8, 1'b0, 1'b1);
        shift_bits(b, 4, 1'b0, 1'b1);
        chk("sat_kcnt", 64'(oKey_bit_counter), 64'd8);
        chk("sat_key", 64'(oKey), 64'(k2));

        // Start refused with 63 message bits, accepted after the 64th
        do_reset();
        a = 64'h0123_4567_89AB_CDEF;
        shift_bits(a >> 1, 63, 1'b1, 1'b0);
        shift_bits(64'hA5, 8, 1'b0, 1'b1);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("early_start_busy", 64'(oBusy), 64'd0);
        chk("early_start_dp_rst_n", 64'(oDp_rst_n), 64'd1);
        chk("early_start_mcnt", 64'(oMessage_bit_counter), 64'd63);
        shift_bits(a, 1, 1'b1, 1'b0);
        chk("full_mcnt", 64'(oMessage_bit_counter), 64'd64);

        push_expected(64'hA486_E0C2_2C0E_684A);
        bit_cnt = 0;
        done_cnt = 0;
        pulse_start();
        @(negedge clk);
        chk("clr_dp_rst_n", 64'(oDp_rst_n), 64'd0);
        chk("clr_dp_ena", 64'(oDp_ena), 64'd0);
        chk("clr_busy", 64'(oBusy), 64'd1);
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            @(negedge clk);
            chk("run_dp_ena", 64'(oDp_ena), 64'd1);
            chk("run_dp_rst_n", 64'(oDp_rst_n), 64'd1);
        end
        @(negedge clk);
        chk("cap_dp_ena", 64'(oDp_ena), 64'd0);
        wait_done();
        chk("first_valid_latency", 64'(first_cyc - start_cyc), 64'd11);
        chk("bit_count", 64'(bit_cnt), 64'd64);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("done_after_last", 64'(done_cyc - last_cyc), 64'd1);
        repeat (2) @(negedge clk);
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("post_msg", oMessage, 64'd0);
        chk("post_mcnt", 64'(oMessage_bit_counter), 64'd0);
        chk("post_kcnt", 64'(oKey_bit_counter), 64'd0);
        chk("post_busy", 64'(oBusy), 64'd0);

        // ena held low for 5 cycles in the middle of SHIFT
        msg2 = 64'hDEAD_BEEF_CAFE_F00D;
        k2 = 8'h3C;
        shift_bits(msg2, 64, 1'b1, 1'b0);
        shift_bits(64'(k2), 8, 1'b0, 1'b1);
        push_expected(ref_cipher(msg2, k2));
        bit_cnt = 0;
        pulse_start();
        for (int t = 0; t < 200 && bit_cnt < 20; t++) @(negedge clk);
        chk("ena_reached_shift", 64'(bit_cnt >= 20), 64'd1);
        @(posedge clk);
        #1 ena = 1'b0;
        held = oSerial_out;
        repeat (5) begin
            @(posedge clk);
            #2;
            chk("hold_vld", 64'(oSerial_valid), 64'd1);
            chk("hold_bit", 64'(oSerial_out), 64'(held));
            chk("hold_busy", 64'(oBusy), 64'd1);
        end
        ena = 1'b1;
        wait_done();
        chk("ena_bit_count", 64'(bit_cnt), 64'd64);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset during RUN abandons the pass
        a = {$urandom, $urandom};
        shift_bits(a, 64, 1'b1, 1'b0);
        shift_bits(64'h5A, 8, 1'b0, 1'b1);
        pulse_start();
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_dp_ena", 64'(oDp_ena), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(oBusy), 64'd0);
        chk("arst_dp_ena", 64'(oDp_ena), 64'd0);
        chk("arst_dp_rst_n", 64'(oDp_rst_n), 64'd1);
        chk("arst_msg", oMessage, 64'd0);
        chk("arst_key", 64'(oKey), 64'd0);
        chk("arst_mcnt", 64'(oMessage_bit_counter), 64'd0);
        chk("arst_vld", 64'(oSerial_valid), 64'd0);
        chk("arst_done", 64'(oDone), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_stays_idle", 64'(oBusy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
